// File: rtl/gpio_port_out_pulse.sv
// GPIO output port with per-channel MODE polarity, STATE register and optional pulse generators.
// Optional feature macro: GPIO_PORT_OUT_PULSE_EN (PULSE_LEN register, per-channel counters,
// PULSE_START). Without it, addresses 0x5/0x6 are ignored and pulse_active is constant 0.
// Writes are two-cycle handshakes: write_single is sampled into a 3-bit history and a write
// commits once, on the edge where the history reads 3'b011, using registered addr/data.
module gpio_port_out_pulse #(
  parameter int unsigned           PORT_WIDTH     = 32,
  parameter int unsigned           PULSE_CNT_W    = 16,
  parameter logic [PORT_WIDTH-1:0] MODE_INIT_VAL  = '1,
  parameter logic [PORT_WIDTH-1:0] STATE_INIT_VAL = '0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    write_single,
  input  logic [3:0]              write_addr,
  input  logic [31:0]             write_data,
  output logic [4*PORT_WIDTH-1:0] readable_reg_extern,
  output logic [PORT_WIDTH-1:0]   port_really_out
);

  localparam logic [3:0] AddrMode   = 4'h0;
  localparam logic [3:0] AddrState  = 4'h1;
  localparam logic [3:0] AddrSet    = 4'h2;
  localparam logic [3:0] AddrClr    = 4'h3;
  localparam logic [3:0] AddrToggle = 4'h4;

  // Reset value of the port: STATE_INIT_VAL passed straight through where MODE is 1, else inverted.
  localparam logic [PORT_WIDTH-1:0] PortInitVal = ~(MODE_INIT_VAL ^ STATE_INIT_VAL);

  logic [2:0]            hist_q;
  logic [3:0]            addr_q;
  logic [31:0]           data_q;
  logic                  commit;
  logic [PORT_WIDTH-1:0] mode_q, mode_d;
  logic [PORT_WIDTH-1:0] state_q, state_d;
  logic [PORT_WIDTH-1:0] port_q, port_d;
  logic [PORT_WIDTH-1:0] pulse_active;

  // Single-edge commit: fires only on the rising history 0->1->1, so a long request commits once.
  assign commit = (hist_q == 3'b011);

  // Request history and registered write address/data.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hist_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      hist_q <= {hist_q[1:0], write_single};
      addr_q <= write_addr;
      data_q <= write_data;
    end
  end

  // MODE and STATE register updates on a committed write.
  always_comb begin
    mode_d  = mode_q;
    state_d = state_q;
    if (commit) begin
      case (addr_q)
        AddrMode:   mode_d  = data_q[PORT_WIDTH-1:0];
        AddrState:  state_d = data_q[PORT_WIDTH-1:0];
        AddrSet:    state_d = state_q | data_q[PORT_WIDTH-1:0];
        AddrClr:    state_d = state_q & ~data_q[PORT_WIDTH-1:0];
        AddrToggle: state_d = state_q ^ data_q[PORT_WIDTH-1:0];
        default:    ;
      endcase
    end
  end

`ifdef GPIO_PORT_OUT_PULSE_EN
  localparam logic [3:0]             AddrPulseLen   = 4'h5;
  localparam logic [3:0]             AddrPulseStart = 4'h6;
  localparam logic [PULSE_CNT_W-1:0] CntOne         = 1;

  logic [PULSE_CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic [PULSE_CNT_W-1:0] cnt_q [PORT_WIDTH];
  logic [PULSE_CNT_W-1:0] cnt_d [PORT_WIDTH];

  // Pulse length register and per-channel counters; a start reloads (retriggers) the counter,
  // and a zero length leaves the counter untouched.
  always_comb begin
    pulse_len_d = pulse_len_q;
    if (commit && (addr_q == AddrPulseLen)) begin
      pulse_len_d = data_q[PULSE_CNT_W-1:0];
    end
    for (int i = 0; i < int'(PORT_WIDTH); i++) begin
      pulse_active[i] = (cnt_q[i] != '0);
      cnt_d[i]        = cnt_q[i];
      if (commit && (addr_q == AddrPulseStart) && data_q[i] && (pulse_len_q != '0)) begin
        cnt_d[i] = pulse_len_q;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
    end
  end

  // Pulse state flops.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pulse_len_q <= '0;
      for (int i = 0; i < int'(PORT_WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      pulse_len_q <= pulse_len_d;
      cnt_q       <= cnt_d;
    end
  end
`else
  assign pulse_active = '0;
`endif

  // Output level: STATE or an active pulse, with MODE selecting direct (1) or inverted (0).
  always_comb begin
    port_d = ~(mode_q ^ (state_q | pulse_active));
  end

  // Control registers and the registered port output.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q  <= MODE_INIT_VAL;
      state_q <= STATE_INIT_VAL;
      port_q  <= PortInitVal;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

  assign port_really_out     = port_q;
  assign readable_reg_extern = {pulse_active, port_q, state_q, mode_q};

endmodule

// File: doc/gpio_port_out_pulse.md
GPIO_PORT_OUT_PULSE -- requirements
Module: gpio_port_out_pulse

Interface
REQ-001 SHALL have parameter PORT_WIDTH, default 32, number of output channels (legal range 1..32).
REQ-002 SHALL have parameter PULSE_CNT_W, default 16, width of each channel's pulse-length counter.
REQ-003 SHALL have parameter MODE_INIT_VAL, default all ones, reset value of the MODE register.
REQ-004 SHALL have parameter STATE_INIT_VAL, default 0, reset value of the STATE register.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port write_single, input, 1 bit: write request, held high at least 2 cycles.
REQ-008 SHALL have port write_addr, input, 4 bits: register address, stable while write_single is high.
REQ-009 SHALL have port write_data, input, 32 bits: write data; only bits [PORT_WIDTH-1:0] are used.
REQ-010 SHALL have port readable_reg_extern, output, 4*PORT_WIDTH bits: {pulse_active, port_really_out, STATE, MODE}, MODE in the LSBs.
REQ-011 SHALL have port port_really_out, output, PORT_WIDTH bits: registered channel outputs.

Function
REQ-012 Every cycle, write_single SHALL shift into a 3-bit history register, and write_addr and write_data SHALL be registered.
REQ-013 A write SHALL commit exactly once, on the edge where the history equals 3'b011, using the registered addr/data; if write_single first goes high at edge N, the commit is at edge N+2.
REQ-014 Address 0x0 SHALL load MODE; per bit, 1 = direct output, 0 = inverted output.
REQ-015 Address 0x1 SHALL load STATE.
REQ-016 Address 0x2 SHALL SET: STATE |= data.
REQ-017 Address 0x3 SHALL CLR: STATE &= ~data.
REQ-018 Address 0x4 SHALL TOGGLE: STATE ^= data.
REQ-019 Address 0x5 SHALL load PULSE_LEN from data[PULSE_CNT_W-1:0]; this value is shared by all channels.
REQ-020 Address 0x6 SHALL be PULSE_START: for each bit i set in data, counter[i] loads PULSE_LEN.
REQ-021 Writes to addresses 0x7..0xF SHALL be ignored, with no state change.
REQ-022 pulse_active[i] SHALL equal (counter[i] != 0); a non-zero counter decrements by 1 per cycle and holds at 0.
REQ-023 Effective level SHALL be eff[i] = STATE[i] | pulse_active[i], and port_really_out[i] is registered as eff[i] when MODE[i]=1, else ~eff[i].
REQ-024 Output latency SHALL be one cycle after the STATE or MODE change, so a STATE commit at edge N+2 is visible on the port after edge N+3.
REQ-025 A PULSE_START SHALL hold pulse_active high for exactly PULSE_LEN cycles, and port_really_out shows the pulse for PULSE_LEN cycles starting one cycle later.
REQ-026 With PULSE_LEN=0, PULSE_START SHALL be a no-op.
REQ-027 A PULSE_START on a channel that is already pulsing SHALL reload its counter (retrigger), with no gap in the pulse.
REQ-028 A STATE, SET, CLR or TOGGLE write during a pulse SHALL update STATE without affecting the counter.
REQ-029 A PULSE_LEN write during a pulse SHALL affect only later starts.
REQ-030 If write_single is held high for longer, there SHALL be still only one commit; a new write needs write_single to be low for at least 1 cycle.

Reset
REQ-031 While sys_rst is high, the design SHALL hold MODE=MODE_INIT_VAL, STATE=STATE_INIT_VAL, PULSE_LEN=0, all counters=0, history=0, and registered addr/data=0.
REQ-032 During reset, port_really_out SHALL be STATE_INIT_VAL with MODE_INIT_VAL polarity applied, computed from the parameters.
REQ-033 A reset asserted mid-pulse or mid-write SHALL abort it immediately, and no commit follows release.

Configuration
REQ-034 Macro GPIO_PORT_OUT_PULSE_EN, when defined, SHALL compile in the PULSE_LEN register, the counters and PULSE_START.
REQ-035 Without GPIO_PORT_OUT_PULSE_EN, addresses 0x5 and 0x6 SHALL be ignored, pulse_active SHALL be constant 0, readable_reg_extern SHALL keep the same width, and no counter flops SHALL be generated.

Verification
REQ-036 Reset release, then write 0x1 = 0x0000_00A5 with MODE all ones -> port_really_out = 0xA5, first visible 4 cycles after write_single rises.
REQ-037 Write MODE = 0xFFFF_FFFE, STATE = 0 -> port_really_out = 0x0000_0001; then SET 0x3, CLR 0x1, TOGGLE 0x4 -> STATE = 0x6.
REQ-038 PULSE_LEN=5, PULSE_START 0x8 with STATE=0 -> port bit 3 high for exactly 5 cycles, and pulse_active[3] is visible in readable_reg_extern.
REQ-039 Retrigger with PULSE_LEN=10: start, then start again 4 cycles later -> bit high for 14 continuous cycles; with PULSE_LEN=0, start -> no pulse.
REQ-040 write_single held high for 8 cycles with TOGGLE 0x1 -> exactly one toggle.
REQ-041 sys_rst asserted mid-pulse -> outputs return to init values asynchronously; with GPIO_PORT_OUT_PULSE_EN undefined, address 0x6 writes leave outputs unchanged.
